// File: rtl/Public_Info.sv
// Shared definitions for the decode-to-issue path: the PC_set packet carried
// through the issue buffer, instruction-class bit positions, the NOP packet
// and the consumed-entry encodings.
package Public_Info;

    // One-hot positions inside PC_set.inst_type
    localparam int INST_NOP = 0;
    localparam int INST_ALU = 1;
    localparam int INST_LD  = 2;
    localparam int INST_ST  = 3;
    localparam int INST_BR  = 4;
    localparam int INST_CSR = 5;
    localparam int INST_MUL = 6;
    localparam int INST_DIV = 7;

    // Entries consumed from the issue buffer in one cycle
    localparam logic [1:0] USING_0 = 2'b00;
    localparam logic [1:0] USING_1 = 2'b01;
    localparam logic [1:0] USING_2 = 2'b10;

    typedef struct packed {
        logic [31:0] pc;
        logic [9:0]  inst_type;
        logic        rf_we;
        logic [4:0]  rf_rd;
        logic [4:0]  rf_raddr1;
        logic [4:0]  rf_raddr2;
        logic [1:0]  type_predict;
        logic        o_inst_lawful;
        logic        ecode_we;
    } PC_set;

    localparam PC_set PC_SET_NOP = '{
        pc:            32'd0,
        inst_type:     10'd1,
        rf_we:         1'b0,
        rf_rd:         5'd0,
        rf_raddr1:     5'd0,
        rf_raddr2:     5'd0,
        type_predict:  2'd0,
        o_inst_lawful: 1'b0,
        ecode_we:      1'b0
    };

    // True when a valid load sitting in a lane register produces a register
    // that the candidate instruction reads; r0 never counts as a dependency.
    function automatic logic load_use(input PC_set lane, input logic lane_vld,
                                      input PC_set cand);
        return lane_vld && lane.inst_type[INST_LD] && lane.rf_we &&
               (lane.rf_rd != 5'd0) &&
               ((cand.rf_raddr1 == lane.rf_rd) || (cand.rf_raddr2 == lane.rf_rd));
    endfunction

endpackage

// File: rtl/issue_dispatch_hazard_check.sv
// issue_hazard_check: combinational issue-count decision for the two buffer
// head entries. Dual-issue checks exist only when DUAL_ISSUE_EN is defined;
// otherwise at most one entry is ever granted.
module issue_hazard_check
    import Public_Info::*;
(
    input  PC_set       set1,
    input  PC_set       set2,
    input  PC_set       lane_a,
    input  PC_set       lane_b,
    input  logic [1:0]  lane_valid,
    input  logic [1:0]  is_valid,
    output logic [1:0]  using_num
);

    logic lu1;
    logic unused_ok;

    assign lu1 = load_use(lane_a, lane_valid[1], set1) |
                 load_use(lane_b, lane_valid[0], set1);

    // Fields such as pc only travel through; fold them so nothing dangles.
    assign unused_ok = ^{set1, set2, lane_a, lane_b, is_valid};

`ifdef DUAL_ISSUE_EN
    logic raw, mem_pair, br_pair, csr_any, div_any, br_pred, bad2, lu2, blk2;

    assign raw      = set1.rf_we && (set1.rf_rd != 5'd0) &&
                      ((set1.rf_rd == set2.rf_raddr1) || (set1.rf_rd == set2.rf_raddr2));
    assign mem_pair = (set1.inst_type[INST_LD] | set1.inst_type[INST_ST]) &
                      (set2.inst_type[INST_LD] | set2.inst_type[INST_ST]);
    assign br_pair  = set1.inst_type[INST_BR] & set2.inst_type[INST_BR];
    assign csr_any  = set1.inst_type[INST_CSR] | set2.inst_type[INST_CSR];
    assign div_any  = set1.inst_type[INST_DIV] | set2.inst_type[INST_DIV];
    assign br_pred  = set1.inst_type[INST_BR] & (set1.type_predict != 2'd0);
    assign bad2     = ~set2.o_inst_lawful | set2.ecode_we;
    assign lu2      = load_use(lane_a, lane_valid[1], set2) |
                      load_use(lane_b, lane_valid[0], set2);
    assign blk2     = raw | mem_pair | br_pair | csr_any | div_any |
                      br_pred | bad2 | lu2;
`endif

    // Grant 0/1/2 entries: set1 gates everything, set2 only joins if clean.
    always_comb begin
        using_num = USING_0;
        if (is_valid[1] && !lu1) begin
            using_num = USING_1;
`ifdef DUAL_ISSUE_EN
            if (is_valid[0] && !blk2)
                using_num = USING_2;
`endif
        end
    end

endmodule

// File: rtl/issue_dispatch.sv
// issue_dispatch: consumer of the decode-to-issue FIFO. Reports how many head
// entries are taken this cycle and registers them into execute lanes a/b.
// Optional feature macro: DUAL_ISSUE_EN (undefined = single issue, lane b
// permanently NOP).
module issue_dispatch
    import Public_Info::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  PC_set       i_PC_set1,
    input  PC_set       i_PC_set2,
    input  logic [1:0]  i_is_valid,
    input  logic        flush_BR,
    input  logic        stall_DCache,
    input  logic        stall_div,
    output logic [1:0]  o_usingNUM,
    output PC_set       o_PC_set_a,
    output PC_set       o_PC_set_b,
    output logic [1:0]  o_issue_valid
);

    logic       stall;
    logic [1:0] n;

    assign stall = stall_DCache | stall_div;

    issue_hazard_check u_hazard (
        .set1       (i_PC_set1),
        .set2       (i_PC_set2),
        .lane_a     (o_PC_set_a),
        .lane_b     (o_PC_set_b),
        .lane_valid (o_issue_valid),
        .is_valid   (i_is_valid),
        .using_num  (n)
    );

    // Nothing is consumed from the buffer in reset, flush or stall cycles.
    always_comb begin
        o_usingNUM = n;
        if (!rstn || flush_BR || stall)
            o_usingNUM = USING_0;
    end

    // Lane registers: reset/flush clear, stall holds, otherwise load grants.
    always_ff @(posedge clk) begin
        if (!rstn || flush_BR) begin
            o_PC_set_a    <= PC_SET_NOP;
            o_PC_set_b    <= PC_SET_NOP;
            o_issue_valid <= 2'b00;
        end else if (!stall) begin
            o_PC_set_a    <= (n != USING_0) ? i_PC_set1 : PC_SET_NOP;
            o_PC_set_b    <= (n == USING_2) ? i_PC_set2 : PC_SET_NOP;
            o_issue_valid <= {n != USING_0, n == USING_2};
        end
    end

endmodule

// File: doc/issue_dispatch.md
# issue_dispatch

Consumer side of the decode-to-issue FIFO. Each cycle it examines the two head entries presented by the issue buffer, decides how many to issue (0, 1 or 2) subject to dual-issue and load-use rules, returns that count to the buffer, and registers the issued packets into the two execute-pipe lanes (a and b).

## Interface
Parameters:
- none; all widths come from the shared package.

Ports:
- clk  in  1  clock.
- rstn  in  1  synchronous reset, active-low.
- i_PC_set1  in  PC_set  buffer head entry (oldest).
- i_PC_set2  in  PC_set  buffer entry after head.
- i_is_valid  in  2  bit1 = set1 valid, bit0 = set2 valid; 2'b01 never occurs.
- flush_BR  in  1  branch-mispredict flush.
- stall_DCache  in  1  DCache miss stall.
- stall_div  in  1  divider busy stall.
- o_usingNUM  out  2  entries consumed this cycle: 2'b00 = 0, 2'b01 = 1, 2'b10 = 2; 2'b11 never driven.
- o_PC_set_a  out  PC_set  lane-a issue register.
- o_PC_set_b  out  PC_set  lane-b issue register.
- o_issue_valid  out  2  bit1 = lane a valid, bit0 = lane b valid.

## Operation
- Stall = stall_DCache | stall_div. Flush has priority over stall.
- o_usingNUM is combinational from the current inputs and the issue registers. It is 0 whenever rstn = 0, flush_BR = 1, or stall = 1.
- Instruction classes come from the one-hot bits of inst_type, at package positions INST_LD, INST_ST, INST_BR, INST_CSR, INST_MUL, INST_DIV.
- Load-use hold:
  - Condition: a valid lane register holds INST_LD with rf_we = 1 and rf_rd != 0, and set1 reads that register through rf_raddr1 or rf_raddr2.
  - Response: issue 0 and insert a bubble.
  - The same check applied to set2 limits the cycle to single issue.
- Set2 is blocked from dual issue when any of the following holds:
  - set1 has rf_we = 1, rf_rd != 0, and rf_rd equals set2 rf_raddr1 or rf_raddr2 (RAW);
  - both instructions are memory ops (LD/ST);
  - both are branches;
  - either is CSR;
  - either is DIV;
  - set1 is a branch with type_predict != 0;
  - set2 o_inst_lawful = 0, or set2 ecode_we = 1.
- Count rule: n = 0 if set1 is invalid or load-use held; n = 1 if set1 is issuable and set2 is invalid or blocked; otherwise n = 2.
- Register update on the clock edge:
  - flush: both lanes load PC_SET_NOP; o_issue_valid = 00.
  - stall: all registers hold.
  - otherwise lane a gets set1 when n ≥ 1, lane b gets set2 when n = 2; o_issue_valid = {n≥1, n==2}. Non-issued lanes load PC_SET_NOP.
- Register 0 never creates a hazard.

## Timing
- Reset (rstn = 0 at edge): o_PC_set_a = o_PC_set_b = PC_SET_NOP, o_issue_valid = 00. o_usingNUM = 00 while rstn is low.
- Issue latency: an entry that is valid at the buffer head in cycle t appears in a lane register at t+1, provided no hazard, stall or flush occurs.
- o_usingNUM takes effect at the same edge the buffer advances its tail, so no entry is consumed twice or lost.
- A load-use bubble lasts exactly 1 cycle: the load moves on to the next stage and the lane register becomes NOP or a new instruction.
- Stall released at cycle t: issuing resumes in t with the held hazard context.
- Flush and stall in the same cycle: flush wins.
- The cycle after a flush: o_usingNUM depends only on the new buffer contents.

## Configuration
- DUAL_ISSUE_EN:
  - Defined: behaviour is as above.
  - Undefined: n ≤ 1 always, lane b is permanently PC_SET_NOP with o_issue_valid[0] = 0, and the set2 checks are compiled out.

## Structure
- Shared package Public_Info holds:
  - PC_set;
  - PC_SET_NOP (inst_type = 10'd1, all other fields 0);
  - INST_* bit-position constants;
  - USING_0/USING_1/USING_2 encodings.
- One sub-module, issue_hazard_check: purely combinational. Inputs are the two sets, the two lane registers and i_is_valid; the output is n. The top module holds only the registers and the stall/flush priority.

## Test plan
- Independent ALU pair (set1 writes r4, set2 reads r5/r6), i_is_valid = 11 → o_usingNUM = 10; next cycle o_issue_valid = 11, lanes hold set1/set2.
- RAW: set1 writes r7, set2 reads r7 → o_usingNUM = 01; next cycle lane a = set1, o_issue_valid = 10.
- Load-use:
  - Stimulus: ld.w r3 issued in lane a; next head reads r3.
  - Response: o_usingNUM = 00 for exactly 1 cycle, o_issue_valid = 00, then 01.
- stall_div high for 3 cycles with valid pair → o_usingNUM = 00 and lanes unchanged for all 3; on release, o_usingNUM = 10.
- flush_BR and stall_DCache asserted together with valid pair → lanes become PC_SET_NOP, o_issue_valid = 00, o_usingNUM = 00.
- Two stores at head, DUAL_ISSUE_EN defined → 01 twice; with DUAL_ISSUE_EN undefined, an independent ALU pair → 01, lane b NOP.
